// File: rtl/mp3_ctrl_pkg.sv
// Shared opcodes, constants and the volume-word helper for the MP3 control arbiter.
// The optional mute feature (MP3_CTRL_MUTE_EN) is selected in mp3_ctrl_arbiter.sv.
package mp3_ctrl_pkg;

    localparam logic [2:0] OP_NOP       = 3'd0;
    localparam logic [2:0] OP_NEXT      = 3'd1;
    localparam logic [2:0] OP_PREV      = 3'd2;
    localparam logic [2:0] OP_VOL_UP    = 3'd3;
    localparam logic [2:0] OP_VOL_DN    = 3'd4;
    localparam logic [2:0] OP_SET_TRACK = 3'd5;
    localparam logic [2:0] OP_SET_VOL   = 3'd6;
    localparam logic [2:0] OP_MUTE      = 3'd7;

    localparam logic [15:0] MUTE_WORD = 16'hFEFE;
    localparam logic [7:0]  ATT_MAX   = 8'hFE;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_APPLY,
        ST_HOLD
    } state_e;

    // VS1053 attenuation for a level; level 0 is the quietest setting.
    function automatic logic [7:0] att_of(input logic [7:0] level,
                                          input int unsigned levels,
                                          input int unsigned step);
        int unsigned a;
        a = (levels - 1 - int'(level)) * step;
        if (a > 32'(ATT_MAX)) begin
            return ATT_MAX;
        end
        return a[7:0];
    endfunction

endpackage

// File: rtl/mp3_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after the pointer wins.
// Produces a one-hot grant, its index and an any-grant flag.
module mp3_rr_arbiter #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    int cand;

    // Scan from the farthest offset down so the nearest request overrides.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        cand    = 0;
        for (int off = N - 1; off >= 0; off--) begin
            cand = int'(ptr_i) + off;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (req_i[cand]) begin
                grant_o       = '0;
                grant_o[cand] = 1'b1;
                idx_o         = IW'(cand);
                any_o         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mp3_ctrl_arbiter.sv
// Merges N_SRC command sources into one track index and one VS1053 volume word.
// Define MP3_CTRL_MUTE_EN to make opcode 7 toggle a mute flag; otherwise it is a NOP.
module mp3_ctrl_arbiter #(
    parameter int N_SRC       = 3,
    parameter int TRACK_W     = 3,
    parameter int N_TRACKS    = 8,
    parameter int VOL_LEVELS  = 16,
    parameter int VOL_STEP    = 8,
    parameter int VOL_DEFAULT = 8,
    parameter int HOLDOFF     = 1000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mode_i,
    input  logic [$clog2(N_SRC)-1:0]   sel_i,
    input  logic [N_SRC-1:0]           cmd_valid_i,
    input  logic [3*N_SRC-1:0]         cmd_op_i,
    input  logic [8*N_SRC-1:0]         cmd_arg_i,
    output logic [N_SRC-1:0]           cmd_ready_o,
    output logic [TRACK_W-1:0]         current_o,
    output logic [15:0]                volume_o,
    output logic                       track_chg_o,
    output logic                       vol_chg_o,
    output logic [$clog2(N_SRC)-1:0]   active_src_o
);
    import mp3_ctrl_pkg::*;

    localparam int IDX_W  = $clog2(N_SRC);
    localparam int HOLD_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_LOAD = (HOLDOFF > 0) ? HOLD_W'(HOLDOFF - 1) : '0;
    localparam logic [7:0]         LVL_MAX   = 8'(VOL_LEVELS - 1);
    localparam logic [7:0]         LVL_DEF   = 8'(VOL_DEFAULT);
    localparam logic [8:0]         TRK_LIM   = 9'(N_TRACKS);
    localparam logic [TRACK_W-1:0] TRK_LAST  = TRACK_W'(N_TRACKS - 1);
    localparam logic [7:0]         ATT_DEF   = att_of(LVL_DEF, VOL_LEVELS, VOL_STEP);

    state_e               state_q;
    logic [2:0]           op_q;
    logic [7:0]           arg_q;
    logic [IDX_W-1:0]     ptr_q;
    logic [IDX_W-1:0]     active_src_q;
    logic [TRACK_W-1:0]   current_q;
    logic [7:0]           level_q;
    logic [15:0]          volume_q;
    logic                 track_chg_q;
    logic                 vol_chg_q;
    logic [HOLD_W-1:0]    hold_cnt_q;

    logic [2:0]           op_arr  [N_SRC];
    logic [7:0]           arg_arr [N_SRC];
    logic [N_SRC-1:0]     sel_hit;
    logic [N_SRC-1:0]     rr_grant;
    logic [IDX_W-1:0]     rr_idx;
    logic                 rr_any;
    logic [N_SRC-1:0]     grant_oh;
    logic                 grant_any;
    logic [IDX_W-1:0]     grant_idx;
    logic [2:0]           g_op;
    logic [7:0]           g_arg;

    logic [TRACK_W-1:0]   track_d;
    logic [7:0]           level_d;
    logic [7:0]           att_d;
    logic [15:0]          volume_d;
    logic                 muted;
    logic                 mute_d;
    logic                 mute_tgl;

`ifdef MP3_CTRL_MUTE_EN
    logic                 mute_q;
    assign muted = mute_q;
`else
    assign muted = 1'b0;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < N_SRC; gi++) begin : g_src
            assign op_arr[gi]  = cmd_op_i[3*gi +: 3];
            assign arg_arr[gi] = cmd_arg_i[8*gi +: 8];
            assign sel_hit[gi] = cmd_valid_i[gi] && (sel_i == IDX_W'(gi));
        end
    endgenerate

    mp3_rr_arbiter #(
        .N  (N_SRC),
        .IW (IDX_W)
    ) u_rr (
        .req_i   (cmd_valid_i),
        .ptr_i   (ptr_q),
        .grant_o (rr_grant),
        .idx_o   (rr_idx),
        .any_o   (rr_any)
    );

    always_comb begin
        grant_oh = mode_i ? sel_hit : rr_grant;
        g_op     = OP_NOP;
        g_arg    = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (grant_oh[i]) begin
                g_op  = op_arr[i];
                g_arg = arg_arr[i];
            end
        end
    end

    assign grant_any = mode_i ? (|sel_hit) : rr_any;
    assign grant_idx = mode_i ? sel_i : rr_idx;

    // Fixed-select acks every valid source so losers drop instead of stalling.
    always_comb begin
        cmd_ready_o = '0;
        if (state_q == ST_IDLE) begin
            cmd_ready_o = mode_i ? cmd_valid_i : rr_grant;
        end
    end

    always_comb begin
        track_d  = current_q;
        level_d  = level_q;
        mute_d   = muted;
        mute_tgl = 1'b0;
        case (op_q)
            OP_NEXT:      track_d = (current_q == TRK_LAST) ? '0 : current_q + 1'b1;
            OP_PREV:      track_d = (current_q == '0) ? TRK_LAST : current_q - 1'b1;
            OP_VOL_UP: begin
                if (level_q != LVL_MAX) begin
                    level_d = level_q + 1'b1;
                end
                mute_d = 1'b0;
            end
            OP_VOL_DN: begin
                if (level_q != '0) begin
                    level_d = level_q - 1'b1;
                end
                mute_d = 1'b0;
            end
            OP_SET_TRACK: begin
                if ({1'b0, arg_q} < TRK_LIM) begin
                    track_d = TRACK_W'(arg_q);
                end
            end
            OP_SET_VOL: begin
                level_d = (arg_q > LVL_MAX) ? LVL_MAX : arg_q;
                mute_d  = 1'b0;
            end
            OP_MUTE: begin
`ifdef MP3_CTRL_MUTE_EN
                mute_d   = !muted;
                mute_tgl = 1'b1;
`endif
            end
            default: ;
        endcase
        att_d    = att_of(level_d, VOL_LEVELS, VOL_STEP);
        volume_d = mute_d ? MUTE_WORD : {att_d, att_d};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            op_q         <= OP_NOP;
            arg_q        <= '0;
            ptr_q        <= '0;
            active_src_q <= '0;
            current_q    <= '0;
            level_q      <= LVL_DEF;
            volume_q     <= {ATT_DEF, ATT_DEF};
            track_chg_q  <= 1'b0;
            vol_chg_q    <= 1'b0;
            hold_cnt_q   <= '0;
`ifdef MP3_CTRL_MUTE_EN
            mute_q       <= 1'b0;
`endif
        end else begin
            track_chg_q <= 1'b0;
            vol_chg_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (grant_any) begin
                        op_q         <= g_op;
                        arg_q        <= g_arg;
                        active_src_q <= grant_idx;
                        if (!mode_i) begin
                            ptr_q <= (rr_idx == IDX_W'(N_SRC - 1)) ? '0 : rr_idx + 1'b1;
                        end
                        state_q <= ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    current_q   <= track_d;
                    level_q     <= level_d;
                    volume_q    <= volume_d;
                    track_chg_q <= (track_d != current_q);
                    vol_chg_q   <= (volume_d != volume_q) || mute_tgl;
`ifdef MP3_CTRL_MUTE_EN
                    mute_q      <= mute_d;
`endif
                    if (HOLDOFF == 0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q    <= ST_HOLD;
                        hold_cnt_q <= HOLD_LOAD;
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt_q == '0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        hold_cnt_q <= hold_cnt_q - 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign current_o    = current_q;
    assign volume_o     = volume_q;
    assign track_chg_o  = track_chg_q;
    assign vol_chg_o    = vol_chg_q;
    assign active_src_o = active_src_q;

endmodule
